// File: rtl/iob_bootrom_arbiter_if.sv
// Boot ROM arbiter bus: two requester ports plus the shared ROM read port.
// The master modport is the arbiter's view; the slave modport is the view of
// the surrounding requesters and ROM macro.
interface iob_bootrom_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);

  logic              r0_ren_i;
  logic [ADDR_W-1:0] r0_raddr_i;
  logic              r0_rready_o;
  logic              r0_rvalid_o;

  logic              r1_ren_i;
  logic [ADDR_W-1:0] r1_raddr_i;
  logic              r1_rready_o;
  logic              r1_rvalid_o;

  logic [DATA_W-1:0] rdata_o;

  logic              rom_ren_o;
  logic [ADDR_W-1:0] rom_raddr_o;
  logic              rom_rready_i;
  logic              rom_rvalid_i;
  logic [DATA_W-1:0] rom_rdata_i;

  modport master (
    input  r0_ren_i, r0_raddr_i, r1_ren_i, r1_raddr_i,
    input  rom_rready_i, rom_rvalid_i, rom_rdata_i,
    output r0_rready_o, r0_rvalid_o, r1_rready_o, r1_rvalid_o, rdata_o,
    output rom_ren_o, rom_raddr_o
  );

  modport slave (
    output r0_ren_i, r0_raddr_i, r1_ren_i, r1_raddr_i,
    output rom_rready_i, rom_rvalid_i, rom_rdata_i,
    input  r0_rready_o, r0_rvalid_o, r1_rready_o, r1_rvalid_o, rdata_o,
    input  rom_ren_o, rom_raddr_o
  );

endinterface

// File: rtl/iob_bootrom_arbiter.sv
// Two-requester arbiter sharing the boot ROM read port between the CSR read
// path (requester 0) and the boot preload engine (requester 1). One ROM read
// is outstanding at a time; the grant is held from address acceptance until
// the data response returns.
// Build option: define IOB_BOOTROM_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority and no round-robin pointer exists.
module iob_bootrom_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,
  iob_bootrom_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StWaitRvalid} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   winner;
  logic   gnt_ren;
  logic [ADDR_W-1:0] gnt_raddr;

`ifdef IOB_BOOTROM_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;

  // Tie goes to the requester indexed by rr_ptr; a lone requester always wins
  always_comb begin
    if (bus.r0_ren_i && bus.r1_ren_i) winner = rr_ptr_q;
    else                              winner = ~bus.r0_ren_i;
  end
`else
  // Fixed priority: requester 0 wins whenever it is requesting
  always_comb begin
    winner = ~bus.r0_ren_i;
  end
`endif

  assign gnt_ren   = grant_q ? bus.r1_ren_i   : bus.r0_ren_i;
  assign gnt_raddr = grant_q ? bus.r1_raddr_i : bus.r0_raddr_i;

  // State register; reset wins over the clock enable
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
`ifdef IOB_BOOTROM_ARB_RR_EN
      rr_ptr_q <= 1'b0;
`endif
    end else if (cke_i) begin
      state_q  <= state_d;
      grant_q  <= grant_d;
`ifdef IOB_BOOTROM_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Next-state logic: arbitrate in idle, hold the grant until the response
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
`ifdef IOB_BOOTROM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.r0_ren_i || bus.r1_ren_i) begin
          grant_d = winner;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // A withdrawn request abandons the grant without touching the ROM
        if (!gnt_ren)                 state_d = StIdle;
        else if (bus.rom_rready_i)    state_d = StWaitRvalid;
      end
      StWaitRvalid: begin
        if (bus.rom_rvalid_i) begin
          state_d  = StIdle;
`ifdef IOB_BOOTROM_ARB_RR_EN
          rr_ptr_d = ~grant_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: ROM request and response routing, all zero while in reset
  always_comb begin
    bus.rom_ren_o   = 1'b0;
    bus.rom_raddr_o = '0;
    bus.r0_rready_o = 1'b0;
    bus.r1_rready_o = 1'b0;
    bus.r0_rvalid_o = 1'b0;
    bus.r1_rvalid_o = 1'b0;
    bus.rdata_o     = '0;
    if (!arst_i) begin
      unique case (state_q)
        StGrant: begin
          bus.rom_ren_o   = gnt_ren;
          bus.rom_raddr_o = gnt_ren ? gnt_raddr : '0;
          if (gnt_ren && bus.rom_rready_i) begin
            bus.r0_rready_o = ~grant_q;
            bus.r1_rready_o = grant_q;
          end
        end
        StWaitRvalid: begin
          if (bus.rom_rvalid_i) begin
            bus.r0_rvalid_o = ~grant_q;
            bus.r1_rvalid_o = grant_q;
            bus.rdata_o     = bus.rom_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_bootrom_arbiter.sv
// Self-checking bench for iob_bootrom_arbiter. Expected responses and grant
// owners are queued when requests are set up and popped as the DUT pulses
// rready/rvalid. A behavioural ROM answers one cycle after accepting an address.
module tb_iob_bootrom_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              owner;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic cke;
  logic arst;

  always #5 clk = ~clk;

  iob_bootrom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_bootrom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i  (clk),
    .cke_i  (cke),
    .arst_i (arst),
    .bus    (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  exp_t exp_q[$];
  bit   gnt_q[$];

  int              req_cnt[2];
  logic [ADDR_W-1:0] req_addr[2];
  int              ack_cnt[2];
  int              rom_acc_cnt = 0;
  int              cyc = 0;
  int              first_rv = -1;
  int              last_rv = -1;
  bit              rom_auto;

  // Snapshot of DUT outputs taken mid-cycle by tick()
  logic              s_rom_ren, s_rr0, s_rr1, s_rv0, s_rv1;
  logic [ADDR_W-1:0] s_rom_raddr;
  logic [DATA_W-1:0] s_rdata;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    if (a == 10'h005) return 32'hDEAD_BEEF;
    return {16'hC0DE, 6'd0, a};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_access(input bit owner, input logic [ADDR_W-1:0] a);
    exp_q.push_back({owner, rom_word(a)});
    gnt_q.push_back(owner);
  endtask

  task automatic drive_reqs();
    bus.r0_ren_i   = (req_cnt[0] > 0);
    bus.r0_raddr_i = (req_cnt[0] > 0) ? req_addr[0] : '0;
    bus.r1_ren_i   = (req_cnt[1] > 0);
    bus.r1_raddr_i = (req_cnt[1] > 0) ? req_addr[1] : '0;
  endtask

  // One clock: sample and score on the falling edge, then drive after the rise
  task automatic tick();
    logic              acc;
    logic [ADDR_W-1:0] acc_addr;
    exp_t              e;
    bit                g;
    @(negedge clk);
    s_rom_ren   = bus.rom_ren_o;
    s_rom_raddr = bus.rom_raddr_o;
    s_rr0       = bus.r0_rready_o;
    s_rr1       = bus.r1_rready_o;
    s_rv0       = bus.r0_rvalid_o;
    s_rv1       = bus.r1_rvalid_o;
    s_rdata     = bus.rdata_o;
    if (s_rv0 || s_rv1) begin
      if (exp_q.size() == 0) begin
        check_eq("rvalid_unexpected", {30'd0, s_rv1, s_rv0}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rvalid_owner", {30'd0, s_rv1, s_rv0}, e.owner ? 32'd2 : 32'd1);
        check_eq("rdata", s_rdata, e.data);
      end
      if (first_rv < 0) first_rv = cyc;
      last_rv = cyc;
    end else begin
      check_eq("rdata_zero", s_rdata, 32'd0);
    end
    if (s_rr0 || s_rr1) begin
      if (gnt_q.size() == 0) begin
        check_eq("rready_unexpected", {30'd0, s_rr1, s_rr0}, 32'd0);
      end else begin
        g = gnt_q.pop_front();
        check_eq("rready_owner", {30'd0, s_rr1, s_rr0}, g ? 32'd2 : 32'd1);
      end
      for (int i = 0; i < 2; i++) begin
        if ((i == 0) ? s_rr0 : s_rr1) begin
          ack_cnt[i]++;
          if (req_cnt[i] > 0) begin
            req_cnt[i]--;
            req_addr[i]++;
          end
        end
      end
    end
    if (!s_rom_ren) check_eq("rom_raddr_zero", {22'd0, s_rom_raddr}, 32'd0);
    acc      = s_rom_ren && bus.rom_rready_i;
    acc_addr = s_rom_raddr;
    if (acc) rom_acc_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (rom_auto) begin
      bus.rom_rvalid_i = acc;
      bus.rom_rdata_i  = acc ? rom_word(acc_addr) : 32'hBAD0_BAD0;
    end
    drive_reqs();
  endtask

  task automatic run_until_done(input int max_cyc);
    int n = 0;
    while ((exp_q.size() > 0 || gnt_q.size() > 0 || req_cnt[0] > 0 || req_cnt[1] > 0)
           && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) check_eq("timeout_pending", exp_q.size() + gnt_q.size(), 0);
  endtask

  task automatic do_reset();
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rom_ren"}, {31'd0, s_rom_ren}, 32'd0);
    check_eq({tag, "_rom_raddr"}, {22'd0, s_rom_raddr}, 32'd0);
    check_eq({tag, "_rready"}, {30'd0, s_rr1, s_rr0}, 32'd0);
    check_eq({tag, "_rvalid"}, {30'd0, s_rv1, s_rv0}, 32'd0);
    check_eq({tag, "_rdata"}, s_rdata, 32'd0);
  endtask

  initial begin
    int acc_before;
    int ack1_before;
    logic [ADDR_W-1:0] a0;
    logic [ADDR_W-1:0] a1;

    cke = 1'b1;
    arst = 1'b1;
    rom_auto = 1'b1;
    req_cnt[0] = 0;
    req_cnt[1] = 0;
    req_addr[0] = '0;
    req_addr[1] = '0;
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    bus.rom_rready_i = 1'b1;
    bus.rom_rvalid_i = 1'b0;
    bus.rom_rdata_i  = '0;
    drive_reqs();

    // Reset state
    tick();
    check_all_zero("rst");
    arst = 1'b0;
    tick();
    check_all_zero("post_rst");

    // Single read from requester 0, 1-cycle ROM
    do_reset();
    req_cnt[0] = 1;
    req_addr[0] = 10'h005;
    expect_access(1'b0, 10'h005);
    drive_reqs();
    tick();
    check_eq("single_c0_rom_ren", {31'd0, s_rom_ren}, 32'd0);
    tick();
    check_eq("single_c1_rom_ren", {31'd0, s_rom_ren}, 32'd1);
    check_eq("single_c1_raddr", {22'd0, s_rom_raddr}, 32'h005);
    check_eq("single_c1_rready0", {31'd0, s_rr0}, 32'd1);
    tick();
    check_eq("single_c2_rvalid0", {31'd0, s_rv0}, 32'd1);
    check_eq("single_c2_rdata", s_rdata, 32'hDEAD_BEEF);
    check_eq("single_r1_acks", ack_cnt[1], 0);

    // Both requesters held for four accesses each
    do_reset();
    req_cnt[0] = 4;
    req_cnt[1] = 4;
    req_addr[0] = 10'h010;
    req_addr[1] = 10'h020;
    a0 = 10'h010;
    a1 = 10'h020;
`ifdef IOB_BOOTROM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin
      expect_access(1'b0, a0);
      a0++;
      expect_access(1'b1, a1);
      a1++;
    end
`else
    for (int i = 0; i < 4; i++) begin
      expect_access(1'b0, a0);
      a0++;
    end
    for (int i = 0; i < 4; i++) begin
      expect_access(1'b1, a1);
      a1++;
    end
`endif
    drive_reqs();
    first_rv = -1;
    run_until_done(100);
    check_eq("b2b_spacing", last_rv - first_rv, 21);

    // ROM back-pressure for five cycles; r0 arrives mid-grant and must wait
    do_reset();
    bus.rom_rready_i = 1'b0;
    req_cnt[1] = 1;
    req_addr[1] = 10'h033;
    expect_access(1'b1, 10'h033);
    drive_reqs();
    tick();
    req_cnt[0] = 1;
    req_addr[0] = 10'h044;
    expect_access(1'b0, 10'h044);
    drive_reqs();
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq("bp_rom_ren", {31'd0, s_rom_ren}, 32'd1);
      check_eq("bp_rom_raddr", {22'd0, s_rom_raddr}, 32'h033);
      check_eq("bp_rready", {30'd0, s_rr1, s_rr0}, 32'd0);
    end
    bus.rom_rready_i = 1'b1;
    tick();
    check_eq("bp_c6_rready", {30'd0, s_rr1, s_rr0}, 32'd2);
    run_until_done(50);

    // Spurious ROM response in idle
    do_reset();
    rom_auto = 1'b0;
    bus.rom_rvalid_i = 1'b1;
    bus.rom_rdata_i  = 32'h1234_5678;
    tick();
    check_eq("spur_rvalid", {30'd0, s_rv1, s_rv0}, 32'd0);
    check_eq("spur_rdata", s_rdata, 32'd0);
    bus.rom_rvalid_i = 1'b0;
    bus.rom_rdata_i  = '0;
    rom_auto = 1'b1;
    req_cnt[0] = 1;
    req_addr[0] = 10'h00B;
    expect_access(1'b0, 10'h00B);
    drive_reqs();
    tick();
    tick();
    check_eq("spur_next_rready0", {31'd0, s_rr0}, 32'd1);
    run_until_done(20);

    // Reset while waiting for the response; the late response is dropped
    do_reset();
    rom_auto = 1'b0;
    bus.rom_rdata_i = '0;
    req_cnt[0] = 1;
    req_addr[0] = 10'h007;
    gnt_q.push_back(1'b0);
    drive_reqs();
    tick();
    tick();
    check_eq("rstw_c1_rready0", {31'd0, s_rr0}, 32'd1);
    arst = 1'b1;
    tick();
    check_all_zero("rstw_in_rst");
    arst = 1'b0;
    bus.rom_rvalid_i = 1'b1;
    bus.rom_rdata_i  = rom_word(10'h007);
    tick();
    check_all_zero("rstw_late");
    bus.rom_rvalid_i = 1'b0;
    bus.rom_rdata_i  = '0;
    rom_auto = 1'b1;
    req_cnt[1] = 1;
    req_addr[1] = 10'h02A;
    expect_access(1'b1, 10'h02A);
    drive_reqs();
    tick();
    tick();
    check_eq("rstw_r1_rready", {30'd0, s_rr1, s_rr0}, 32'd2);
    run_until_done(20);

    // Requester 1 withdraws while the ROM is stalled
    do_reset();
    bus.rom_rready_i = 1'b0;
    acc_before = rom_acc_cnt;
    ack1_before = ack_cnt[1];
    req_cnt[1] = 1;
    req_addr[1] = 10'h03C;
    drive_reqs();
    tick();
    tick();
    check_eq("wd_c1_rom_ren", {31'd0, s_rom_ren}, 32'd1);
    req_cnt[1] = 0;
    drive_reqs();
    tick();
    check_eq("wd_c2_rom_ren", {31'd0, s_rom_ren}, 32'd0);
    bus.rom_rready_i = 1'b1;
    tick();
    check_eq("wd_c3_rom_ren", {31'd0, s_rom_ren}, 32'd0);
    check_eq("wd_no_rom_access", rom_acc_cnt - acc_before, 0);
    check_eq("wd_no_r1_ack", ack_cnt[1] - ack1_before, 0);
    req_cnt[0] = 1;
    req_addr[0] = 10'h00C;
    expect_access(1'b0, 10'h00C);
    drive_reqs();
    tick();
    tick();
    check_eq("wd_next_rready0", {31'd0, s_rr0}, 32'd1);
    run_until_done(20);

    // Clock enable low freezes the idle state
    do_reset();
    cke = 1'b0;
    req_cnt[0] = 1;
    req_addr[0] = 10'h015;
    expect_access(1'b0, 10'h015);
    drive_reqs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("cke_hold_rom_ren", {31'd0, s_rom_ren}, 32'd0);
    end
    cke = 1'b1;
    tick();
    tick();
    check_eq("cke_resume_rready0", {31'd0, s_rr0}, 32'd1);
    run_until_done(20);

    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("gnt_q_drained", gnt_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
